// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with a circular return-address stack.
// Selects the next fetch address from reset vector, exception vector, branch
// target, RAS prediction, jump target or sequential increment, honouring the
// start_i run enable and the PCWrite_i hazard stall.
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   start_i          run enable; low freezes PC and RAS
//   PCWrite_i        advance enable; low stalls (exceptions still taken)
//   exc_i            exception redirect to EXC_VEC
//   branch_i         taken-branch redirect to branch_target_i
//   jump_i           direct jump to jump_target_i
//   call_i           push ret_addr_i onto the RAS
//   ret_i            return; pop RAS, or use ret_target_i when RAS is empty
//   pc_o             current fetch address (registered)
//   pc_plus4_o       pc_o + 4 (combinational)
//   valid_o          pc_o is a live fetch address (sticky until reset)
//   ras_empty_o      RAS holds no entries
//   ras_full_o       RAS holds RAS_DEPTH entries
module pc_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0080,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             PCWrite_i,
    input  logic             exc_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_target_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             call_i,
    input  logic [WIDTH-1:0] ret_addr_i,
    input  logic             ret_i,
    input  logic [WIDTH-1:0] ret_target_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             valid_o,
    output logic             ras_empty_o,
    output logic             ras_full_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VEC);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q,    pc_d;
    logic             valid_q, valid_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic             ras_we;
    logic [PTR_W-1:0] ras_waddr;
    logic             pop;
    logic             push;
    logic             empty;
    logic             full;

    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == CNT_MAX);
    assign pc_o        = pc_q;
    assign valid_o     = valid_q;
    assign pc_plus4_o  = pc_q + WIDTH'(4);
    assign ras_empty_o = empty;
    assign ras_full_o  = full;

    // Next-state selection; reset is applied in the register process.
    always_comb begin
        pc_d      = pc_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        pop       = 1'b0;
        push      = 1'b0;

        if (!rst_i && start_i) begin
            valid_d = 1'b1;
            if (exc_i) begin
                // Exception flushes the prediction stack; pointer position is irrelevant.
                pc_d  = EXC_PC;
                cnt_d = '0;
            end else if (PCWrite_i) begin
                push = call_i & ~branch_i;

                if (branch_i) begin
                    pc_d = branch_target_i;
                end else if (ret_i) begin
                    if (empty) begin
                        pc_d = ret_target_i;
                    end else begin
                        pc_d = ras_mem[ptr_q];
                        pop  = 1'b1;
                    end
                end else if (jump_i) begin
                    pc_d = jump_target_i;
                end else begin
                    pc_d = pc_plus4_o;
                end

                if (pop && push) begin
                    // Pop then push lands in the same slot: replace top in place.
                    ras_we    = 1'b1;
                    ras_waddr = ptr_q;
                end else if (push) begin
                    // When full the increment wraps onto the oldest entry.
                    ptr_d     = ptr_q + PTR_W'(1);
                    ras_we    = 1'b1;
                    ras_waddr = ptr_d;
                    if (!full) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (pop) begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAS storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (ras_we) begin
            ras_mem[ras_waddr] <= ret_addr_i;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int unsigned DEPTH = 4;

    // Control bit masks: {rst, start, pcwrite, exc, branch, jump, call, ret}
    localparam logic [7:0] R = 8'h80;
    localparam logic [7:0] S = 8'h40;
    localparam logic [7:0] W = 8'h20;
    localparam logic [7:0] E = 8'h10;
    localparam logic [7:0] B = 8'h08;
    localparam logic [7:0] J = 8'h04;
    localparam logic [7:0] C = 8'h02;
    localparam logic [7:0] T = 8'h01;

    logic        clk = 1'b0;
    logic        rst, start, pcw, exc, br, jmp, call, ret;
    logic [31:0] bt, jt, ra, rt;

    logic [31:0] pc32, p4_32;
    logic        v32, e32, f32;
    logic [7:0]  pc8, p4_8;
    logic        v8, e8, f8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(DEPTH)) dut32 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw), .exc_i(exc),
        .branch_i(br), .branch_target_i(bt), .jump_i(jmp), .jump_target_i(jt),
        .call_i(call), .ret_addr_i(ra), .ret_i(ret), .ret_target_i(rt),
        .pc_o(pc32), .pc_plus4_o(p4_32), .valid_o(v32),
        .ras_empty_o(e32), .ras_full_o(f32)
    );

    pc_unit #(.WIDTH(8), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(DEPTH)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw), .exc_i(exc),
        .branch_i(br), .branch_target_i(bt[7:0]), .jump_i(jmp), .jump_target_i(jt[7:0]),
        .call_i(call), .ret_addr_i(ra[7:0]), .ret_i(ret), .ret_target_i(rt[7:0]),
        .pc_o(pc8), .pc_plus4_o(p4_8), .valid_o(v8),
        .ras_empty_o(e8), .ras_full_o(f8)
    );

    // Reference model: PC per spec priority list, RAS as a bounded stack list
    // where overflow discards the oldest (bottom) element.
    logic [31:0] m_pc    [2];
    logic        m_valid [2];
    logic [31:0] m_stk   [2][DEPTH];
    int          m_sz    [2];

    function automatic logic [31:0] mask_of(int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    task automatic model_step(int k);
        logic [31:0] m;
        logic [31:0] nxt;
        m = mask_of(k);
        if (rst) begin
            m_pc[k] = 32'h0; m_valid[k] = 1'b0; m_sz[k] = 0;
        end else if (start) begin
            m_valid[k] = 1'b1;
            if (exc) begin
                m_pc[k] = 32'h80 & m; m_sz[k] = 0;
            end else if (pcw) begin
                if (br) nxt = bt;
                else if (ret) begin
                    if (m_sz[k] > 0) begin m_sz[k]--; nxt = m_stk[k][m_sz[k]]; end
                    else nxt = rt;
                end
                else if (jmp) nxt = jt;
                else nxt = m_pc[k] + 32'd4;
                if (call && !br) begin
                    if (m_sz[k] == DEPTH) begin
                        for (int i = 0; i < DEPTH - 1; i++) m_stk[k][i] = m_stk[k][i+1];
                        m_sz[k]--;
                    end
                    m_stk[k][m_sz[k]] = ra & m;
                    m_sz[k]++;
                end
                m_pc[k] = nxt & m;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(int k, string tag);
        logic [31:0] m;
        m = mask_of(k);
        if (k == 0) begin
            chk({tag, " pc32"},    pc32,  m_pc[0]);
            chk({tag, " p4_32"},   p4_32, (m_pc[0] + 32'd4) & m);
            chk({tag, " valid32"}, 32'(v32), 32'(m_valid[0]));
            chk({tag, " empty32"}, 32'(e32), 32'(m_sz[0] == 0));
            chk({tag, " full32"},  32'(f32), 32'(m_sz[0] == DEPTH));
        end else begin
            chk({tag, " pc8"},    32'(pc8),  m_pc[1]);
            chk({tag, " p4_8"},   32'(p4_8), (m_pc[1] + 32'd4) & m);
            chk({tag, " valid8"}, 32'(v8), 32'(m_valid[1]));
            chk({tag, " empty8"}, 32'(e8), 32'(m_sz[1] == 0));
            chk({tag, " full8"},  32'(f8), 32'(m_sz[1] == DEPTH));
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, sample #1 later.
    task automatic step(logic [7:0] ctl, logic [31:0] b, logic [31:0] j,
                        logic [31:0] a, logic [31:0] r);
        {rst, start, pcw, exc, br, jmp, call, ret} = ctl;
        bt = b; jt = j; ra = a; rt = r;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] bt, jt, ra, rt;
        logic [31:0] epc;
        logic [2:0]  eflg;   // {valid, empty, full}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] ctl, logic [31:0] b, logic [31:0] j,
                                logic [31:0] a, logic [31:0] r,
                                logic [31:0] epc, logic [2:0] eflg);
        vec_t v;
        v.ctl = ctl; v.bt = b; v.jt = j; v.ra = a; v.rt = r;
        v.epc = epc; v.eflg = eflg;
        return v;
    endfunction

    initial begin
        {rst, start, pcw, exc, br, jmp, call, ret} = 8'h0;
        bt = '0; jt = '0; ra = '0; rt = '0;

        // reset + sequential
        tbl.push_back(mk(R,         0, 0, 0, 0, 32'h0,  3'b010));
        tbl.push_back(mk(R,         0, 0, 0, 0, 32'h0,  3'b010));
        tbl.push_back(mk(S|W,       0, 0, 0, 0, 32'h4,  3'b110));
        tbl.push_back(mk(S|W,       0, 0, 0, 0, 32'h8,  3'b110));
        tbl.push_back(mk(S|W,       0, 0, 0, 0, 32'hC,  3'b110));
        tbl.push_back(mk(S|W,       0, 0, 0, 0, 32'h10, 3'b110));
        // stall with jump, then start low with exception
        tbl.push_back(mk(S|J,       0, 32'h300, 0, 0, 32'h10, 3'b110));
        tbl.push_back(mk(S|J,       0, 32'h300, 0, 0, 32'h10, 3'b110));
        tbl.push_back(mk(S|J,       0, 32'h300, 0, 0, 32'h10, 3'b110));
        tbl.push_back(mk(E,         0, 0, 0, 0, 32'h10, 3'b110));
        // push one entry, then everything at once: exception wins and flushes
        tbl.push_back(mk(S|W|C,     0, 0, 32'h44, 0, 32'h14, 3'b100));
        tbl.push_back(mk(S|W|E|B|T|J, 32'h200, 32'h300, 0, 32'h40, 32'h80, 3'b110));
        tbl.push_back(mk(S|W|B|J,   32'h200, 32'h300, 0, 0, 32'h200, 3'b110));
        // call/call/ret/ret/ret-empty
        tbl.push_back(mk(S|W|J|C,   0, 32'h100, 32'h104, 0, 32'h100, 3'b100));
        tbl.push_back(mk(S|W|J|C,   0, 32'h300, 32'h208, 0, 32'h300, 3'b100));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'h208, 3'b100));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'h104, 3'b110));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'h40,  3'b110));
        // overflow: five pushes, five pops
        tbl.push_back(mk(S|W|C,     0, 0, 32'hA0, 0, 32'h44, 3'b100));
        tbl.push_back(mk(S|W|C,     0, 0, 32'hB0, 0, 32'h48, 3'b100));
        tbl.push_back(mk(S|W|C,     0, 0, 32'hC0, 0, 32'h4C, 3'b100));
        tbl.push_back(mk(S|W|C,     0, 0, 32'hD0, 0, 32'h50, 3'b101));
        tbl.push_back(mk(S|W|C,     0, 0, 32'hE0, 0, 32'h54, 3'b101));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'hE0, 3'b100));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'hD0, 3'b100));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'hC0, 3'b100));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'hB0, 3'b110));
        tbl.push_back(mk(S|W|T,     0, 0, 0, 32'h40, 32'h40, 3'b110));
        // stalled call does not push; call with branch does not push
        tbl.push_back(mk(S|C,       0, 0, 32'h77, 0, 32'h40, 3'b110));
        tbl.push_back(mk(S|W|B|C,   32'h500, 0, 32'h88, 0, 32'h500, 3'b110));
        // 32-bit wrap
        tbl.push_back(mk(S|W|J,     0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 3'b110));
        tbl.push_back(mk(S|W,       0, 0, 0, 0, 32'h0, 3'b110));
        // reset overrides exception and call; valid needs start to rise again
        tbl.push_back(mk(R|S|W|E|C, 0, 0, 32'h99, 0, 32'h0, 3'b010));
        tbl.push_back(mk(8'h00,     0, 0, 0, 0, 32'h0, 3'b010));
        tbl.push_back(mk(S|W,       0, 0, 0, 0, 32'h4, 3'b110));

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].ctl, tbl[i].bt, tbl[i].jt, tbl[i].ra, tbl[i].rt);
            chk($sformatf("vec%0d pc", i),    pc32, tbl[i].epc);
            chk($sformatf("vec%0d pc+4", i),  p4_32, tbl[i].epc + 32'd4);
            chk($sformatf("vec%0d flags", i), 32'({v32, e32, f32}), 32'(tbl[i].eflg));
            check_model(1, $sformatf("vec%0d", i));
        end

        // 8-bit wrap and simultaneous call/ret replacing the top
        step(S|W|J, 0, 32'hFC, 0, 0);
        chk("wrap_a pc32", pc32, 32'hFC);
        chk("wrap_a pc8",  32'(pc8), 32'hFC);
        chk("wrap_a p4_8", 32'(p4_8), 32'h00);
        step(S|W, 0, 0, 0, 0);
        chk("wrap_b pc32", pc32, 32'h100);
        chk("wrap_b pc8",  32'(pc8), 32'h00);
        step(S|W|J|C, 0, 32'h10, 32'h50, 0);
        chk("cr_push pc8",   32'(pc8), 32'h10);
        chk("cr_push empty", 32'({e8, e32}), 32'h0);
        step(S|W|C|T, 0, 0, 32'h60, 32'h33);
        chk("cr_both pc8",   32'(pc8), 32'h50);
        chk("cr_both pc32",  pc32, 32'h50);
        chk("cr_both flags", 32'({e8, f8, e32, f32}), 32'h0);
        step(S|W|T, 0, 0, 0, 32'h33);
        chk("cr_pop pc8",   32'(pc8), 32'h60);
        chk("cr_pop pc32",  pc32, 32'h60);
        chk("cr_pop empty", 32'({e8, e32}), 32'h3);

        // randomized stimulus against the model
        for (int n = 0; n < 600; n++) begin
            logic [7:0] ctl;
            ctl = 8'h0;
            if ($urandom_range(0, 49) == 0) ctl |= R;
            if ($urandom_range(0, 7)  != 0) ctl |= S;
            if ($urandom_range(0, 3)  != 0) ctl |= W;
            if ($urandom_range(0, 19) == 0) ctl |= E;
            if ($urandom_range(0, 5)  == 0) ctl |= B;
            if ($urandom_range(0, 3)  == 0) ctl |= J;
            if ($urandom_range(0, 2)  == 0) ctl |= C;
            if ($urandom_range(0, 2)  == 0) ctl |= T;
            step(ctl, $urandom, $urandom, $urandom, $urandom);
            check_model(0, $sformatf("rnd%0d", n));
            check_model(1, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined CPU's IF stage. It holds the fetch address and selects the next PC from the following sources: reset vector, exception vector, branch target, return-address-stack (RAS) prediction, jump target, or sequential increment. It honours the start and PCWrite stall controls and maintains a circular RAS for call/return prediction.

## Interface
Parameters:
- WIDTH, 32, PC width in bits (≥8)
- RESET_VEC, 0, PC value after reset
- EXC_VEC, 32'h0000_0080, exception handler address (truncated to WIDTH)
- RAS_DEPTH, 4, return-address-stack entries (power of 2, ≥2)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  run enable; low freezes PC and RAS
- PCWrite_i  in  1  high = advance PC; low = stall (hazard unit)
- exc_i  in  1  exception redirect
- branch_i  in  1  taken branch / mispredict redirect
- branch_target_i  in  WIDTH  branch destination
- jump_i  in  1  direct jump (j/jal)
- jump_target_i  in  WIDTH  jump destination
- call_i  in  1  push ret_addr_i onto RAS (jal)
- ret_addr_i  in  WIDTH  return address to push
- ret_i  in  1  return (jr $ra); pop RAS
- ret_target_i  in  WIDTH  register-file $ra, used when RAS is empty
- pc_o  out  WIDTH  current fetch address
- pc_plus4_o  out  WIDTH  pc_o + 4 (combinational)
- valid_o  out  1  pc_o is a live fetch address
- ras_empty_o  out  1  RAS count == 0
- ras_full_o  out  1  RAS count == RAS_DEPTH

## Operation
- Update enable:
  - upd = start_i & PCWrite_i.
  - Exception enable: exc = start_i & exc_i. An exception ignores PCWrite_i.
- Next-PC priority, evaluated at each rising edge:
  1. rst_i → RESET_VEC
  2. exc → EXC_VEC
  3. !upd → hold
  4. branch_i → branch_target_i
  5. ret_i → RAS top if not empty, else ret_target_i
  6. jump_i → jump_target_i
  7. otherwise → pc_o + 4
- Arithmetic: the increment is modulo 2^WIDTH. PC all-ones-minus-3 + 4 wraps to 0. No alignment checking.
- RAS: circular buffer with top pointer and a saturating count (0..RAS_DEPTH).
  - Pop occurs only when the ret source is selected (row 5) and count > 0. The pointer decrements and the count decrements.
  - Push occurs when upd & call_i and no exception, rst, or branch_i is active in that cycle.
    - The pointer increments and ret_addr_i is written.
    - If full, the oldest entry is overwritten and count stays at RAS_DEPTH.
  - Call and ret in the same cycle: the pop supplies the next PC, then the push writes into the popped slot. The pointer and count are unchanged and the top is replaced.
  - An exception clears the count (flush). Branch redirects leave the RAS untouched.
- valid_o: cleared by reset and set at the first edge where start_i = 1. It is sticky until rst_i.
- A start_i low freezes everything, including exception handling. Pending inputs are ignored, not queued.

## Timing
- Every redirect has 1-cycle latency: the source is asserted at edge N, and pc_o shows the new value after edge N.
- pc_plus4_o, ras_empty_o and ras_full_o are combinational from registered state. They are valid in the same cycle as pc_o.
- Reset values: pc_o = RESET_VEC, valid_o = 0, RAS count = 0 (ras_empty_o = 1, ras_full_o = 0). RAS contents are don't-care.
- Reset mid-operation (any cycle) overrides all sources, including exc_i and call_i. No push occurs.
- Stall: while PCWrite_i = 0, pc_o is stable, and call_i/ret_i/branch_i/jump_i have no effect on the RAS or the PC.

## Test plan
- Reset + sequential: RESET_VEC = 0, rst for 2 cycles, start_i = 1, PCWrite_i = 1 for 4 cycles → pc_o 0, 4, 8, 12, 16. valid_o rises after the first start edge.
- Stall and start: at pc_o = 0x10, PCWrite_i = 0 for 3 cycles with jump_i = 1 → pc_o holds 0x10. Then start_i = 0 with exc_i = 1 → pc_o still 0x10.
- Priority: in one cycle assert exc_i, branch_i (0x200), ret_i and jump_i (0x300) → pc_o = 0x80 and RAS flushed. Next cycle assert branch_i and jump_i → pc_o = 0x200.
- RAS push/pop: call 0x104, then call 0x208, then ret, then ret → pc_o = 0x208 then 0x104. A third ret with ret_target_i = 0x40 → pc_o = 0x40 and ras_empty_o = 1.
- RAS overflow with RAS_DEPTH = 4: push 0xA0, 0xB0, 0xC0, 0xD0, 0xE0 → ras_full_o = 1. Five pops yield 0xE0, 0xD0, 0xC0, 0xB0, then ret_target_i on the fifth pop.
- Wrap + simultaneous call/ret (WIDTH = 8): pc_o = 0xFC → next is 0x00. Stack top 0x50, then call_i (0x60) with ret_i → pc_o = 0x50, top = 0x60, count unchanged.
